servo_pwm_array: RTL
====================

// Module: servo_pwm_array
// PURPOSE
//  Multi-channel hobby-servo PWM generator with per-channel angle targets and slew-rate limiting.
//  Replaces the single-channel angle-to-PWM driver in the robot vision platform (pan/tilt plus arm joints).
//  The host writes target angles over a valid/ready port. Each channel ramps toward its target by a bounded step per frame.
//  Pulse widths change only at frame boundaries, so no output ever shows a truncated or stretched pulse.
// PARAMETERS
//  NUM_CH     4          number of servo channels (1..16)
//  PERIOD_CYC 1_000_000  frame length in clk cycles (20 ms @ 50 MHz)
//  MIN_PULSE  25_000     high time for angle 0, in cycles (0.5 ms)
//  STEP_CYC   555        additional high cycles per degree
//  ANGLE_MAX  180        largest legal angle; larger writes clamp to this
//  HOME_DEG   90         reset angle for every channel (current and target)
//  SLEW_DEG   2          max degrees moved per frame per channel; 0 = unlimited (jump directly to target)
// PORTS
//  clk         in   1         system clock, 50 MHz
//  rst         in   1         asynchronous active-high reset
//  wr_valid    in   1         target-write request
//  wr_ready    out  1         write accepted when wr_valid&wr_ready at posedge
//  wr_ch       in   4         channel index of the write
//  wr_angle    in   8         target angle in degrees
//  ch_en       in   NUM_CH    per-channel output enable; 0 forces pwm low
//  pwm         out  NUM_CH    servo PWM outputs
//  settled     out  NUM_CH    1 when current angle == target angle
//  frame_start out  1         one-cycle pulse on the first cycle of each frame
//  wr_err      out  1         one-cycle pulse when a handshaked write has wr_ch >= NUM_CH
// BEHAVIOUR
//  Reset values: cnt=0; cur[i]=tgt[i]=HOME_DEG; width_act[i]=width_pend[i]=MIN_PULSE+HOME_DEG*STEP_CYC.
//   Outputs: pwm=0, frame_start=0, wr_err=0, wr_ready=1, settled=all 1.
//  Frame counter: cnt runs 0..PERIOD_CYC-1, then wraps to 0.
//   frame_start is registered and asserts on the cycle cnt==0.
//  PWM: pwm[i] <= ch_en[i] && (cnt < width_act[i]), registered, so 1-cycle latency from cnt.
//   High time is exactly width_act[i] cycles per frame.
//  Write: on wr_valid&wr_ready, tgt[wr_ch] <= min(wr_angle, ANGLE_MAX).
//   wr_ch >= NUM_CH leaves all state unchanged and pulses wr_err the next cycle.
//   Back-to-back writes to the same channel: the last one wins.
//  FSM IDLE -> UPDATE -> HOLD -> IDLE:
//   IDLE->UPDATE when cnt == PERIOD_CYC-2-NUM_CH. wr_ready=0 from UPDATE entry until return to IDLE.
//   UPDATE processes one channel per cycle, k=0..NUM_CH-1:
//    d = tgt[k]-cur[k]; cur[k] moves toward tgt[k] by min(|d|, SLEW_DEG), or by |d| if SLEW_DEG=0.
//    width_pend[k] <= MIN_PULSE + cur_next[k]*STEP_CYC.
//   HOLD waits for the wrap. On the cycle cnt wraps to 0: width_act <= width_pend (all channels simultaneously); FSM -> IDLE.
//  Arithmetic: angle 8 bits unsigned. Width register is clog2(PERIOD_CYC) bits wide; one multiply per UPDATE cycle.
//   Elaboration check: MIN_PULSE+ANGLE_MAX*STEP_CYC < PERIOD_CYC and PERIOD_CYC > NUM_CH+4.
//  settled[i] is registered and compares cur[i] and tgt[i] (compare cur against tgt, not against width).
//  ch_en low mid-pulse drops pwm on the next cycle. ch_en high mid-frame raises pwm only while cnt < width_act.
//   Angle tracking continues while a channel is disabled.
//  Reset mid-frame or mid-UPDATE returns everything to reset values at once. No partial update survives.
// STRUCTURE
//  Package servo_pkg holds the FSM state encoding, default timing constants,
//   and function angle_to_cycles(angle) = MIN_PULSE + angle*STEP_CYC.
//  Sub-module servo_frame_timer: cnt, frame_start, and a prep strobe at PERIOD_CYC-2-NUM_CH.
//   The top level holds the target/current registers, the UPDATE FSM, and the per-channel comparators.
// TESTING (NUM_CH=4, PERIOD_CYC=2000, MIN_PULSE=100, STEP_CYC=5, HOME_DEG=90, SLEW_DEG=2, ANGLE_MAX=180)
//  1 Reset, ch_en=4'hF, no writes -> every pwm high 550 cycles per 2000-cycle frame; settled=4'hF; frame_start every 2000 cycles.
//  2 Write ch1=100 mid-frame -> current frame unchanged. Next 5 frames widths 560,570,580,590,600.
//     settled[1]=0 until the 5th update, then 1.
//  3 Write ch2=250 -> clamps to 180; width ramps up 10 cycles per frame to 1000. Write ch7 -> wr_err pulse, no state change.
//  4 Hold wr_valid through the UPDATE window -> wr_ready low exactly NUM_CH+1..+2 cycles; the write lands right after.
//     No write is lost or duplicated.
//  5 Assert rst at cnt=300 during a ramp -> pwm=0 immediately. After release: cnt restarts at 0, all widths 550, settled=4'hF.
//  6 SLEW_DEG=0 build, write ch0=0 -> next frame width 100 with no ramp; deassert ch_en[0] mid-pulse -> pwm[0] low next cycle.

Source files
------------

// File: rtl/servo_pkg.sv
// servo_pkg: FSM encoding, default timing constants and angle-to-width conversion
package servo_pkg;
    typedef enum logic [1:0] {IDLE, UPDATE, HOLD} state_t;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_PERIOD_CYC = 1_000_000;
    localparam int DEF_MIN_PULSE = 25_000;
    localparam int DEF_STEP_CYC = 555;
    localparam int DEF_ANGLE_MAX = 180;
    localparam int DEF_HOME_DEG = 90;
    localparam int DEF_SLEW_DEG = 2;
    function automatic int angle_to_cycles(input int angle, input int min_pulse, input int step_cyc);
        return min_pulse + angle * step_cyc;
    endfunction
endpackage

// File: rtl/servo_wr_if.sv
// servo_wr_if: host target-angle write port
interface servo_wr_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_ch;
    logic [7:0] wr_angle;
    logic       wr_err;
    modport master(output wr_valid, wr_ch, wr_angle, input wr_ready, wr_err);
    modport slave(input wr_valid, wr_ch, wr_angle, output wr_ready, wr_err);
endinterface

// File: rtl/servo_frame_timer.sv
// servo_frame_timer: frame counter with frame-start pulse, update-prep strobe and wrap flag
module servo_frame_timer #(
    parameter int PERIOD_CYC = 1_000_000,
    parameter int NUM_CH = 4,
    parameter int W = $clog2(PERIOD_CYC)
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] cnt,
    output logic         frame_start,
    output logic         prep,
    output logic         wrap
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         frame_start_q, frame_start_d;

    always_comb begin
        wrap = cnt_q == W'(PERIOD_CYC - 1);
        prep = cnt_q == W'(PERIOD_CYC - 2 - NUM_CH);
        cnt_d = wrap ? '0 : cnt_q + W'(1);
        frame_start_d = cnt_d == '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign cnt = cnt_q;
    assign frame_start = frame_start_q;
endmodule

// File: rtl/servo_pwm_array.sv
// servo_pwm_array: multi-channel servo PWM with slew-limited angle tracking and frame-aligned width updates
module servo_pwm_array
    import servo_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int MIN_PULSE = DEF_MIN_PULSE,
    parameter int STEP_CYC = DEF_STEP_CYC,
    parameter int ANGLE_MAX = DEF_ANGLE_MAX,
    parameter int HOME_DEG = DEF_HOME_DEG,
    parameter int SLEW_DEG = DEF_SLEW_DEG
) (
    input  logic              clk,
    input  logic              rst,
    servo_wr_if.slave         wr,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] pwm,
    output logic [NUM_CH-1:0] settled,
    output logic              frame_start
);
    localparam int W = $clog2(PERIOD_CYC);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [W-1:0] HOME_W = W'(angle_to_cycles(HOME_DEG, MIN_PULSE, STEP_CYC));
    localparam logic [7:0] HOME_A = 8'(HOME_DEG);
    localparam logic [7:0] AMAX_A = 8'(ANGLE_MAX);
    localparam logic [7:0] SLEW_A = 8'(SLEW_DEG);

    if (MIN_PULSE + ANGLE_MAX * STEP_CYC >= PERIOD_CYC || PERIOD_CYC <= NUM_CH + 4) begin : g_bad_cfg
        $error("servo_pwm_array: pulse range or channel count does not fit in one frame");
    end

    logic [W-1:0]      cnt;
    logic              prep, wrap, hs;
    state_t            state_q, state_d;
    logic [CW-1:0]     idx_q, idx_d, wr_idx;
    logic [7:0]        tgt_q [NUM_CH];
    logic [7:0]        tgt_d [NUM_CH];
    logic [7:0]        cur_q [NUM_CH];
    logic [7:0]        cur_d [NUM_CH];
    logic [W-1:0]      width_pend_q [NUM_CH];
    logic [W-1:0]      width_pend_d [NUM_CH];
    logic [W-1:0]      width_act_q [NUM_CH];
    logic [W-1:0]      width_act_d [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d, settled_q, settled_d;
    logic              wr_ready_q, wr_ready_d, wr_err_q, wr_err_d;
    logic [7:0]        c, t, diff, step, nxt;

    servo_frame_timer #(.PERIOD_CYC(PERIOD_CYC), .NUM_CH(NUM_CH), .W(W)) u_timer (
        .clk(clk),
        .rst(rst),
        .cnt(cnt),
        .frame_start(frame_start),
        .prep(prep),
        .wrap(wrap)
    );

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        tgt_d = tgt_q;
        cur_d = cur_q;
        width_pend_d = width_pend_q;
        width_act_d = width_act_q;
        hs = wr.wr_valid && wr_ready_q;
        wr_idx = CW'(wr.wr_ch);
        wr_err_d = hs && 32'(wr.wr_ch) >= NUM_CH;
        if (hs && !wr_err_d) tgt_d[wr_idx] = wr.wr_angle > AMAX_A ? AMAX_A : wr.wr_angle;
        // one channel per UPDATE cycle: step toward target, bounded by the slew limit
        c = cur_q[idx_q];
        t = tgt_q[idx_q];
        diff = t > c ? t - c : c - t;
        step = (SLEW_DEG == 0 || diff < SLEW_A) ? diff : SLEW_A;
        nxt = t > c ? c + step : c - step;
        if (state_q == IDLE && prep) begin
            state_d = UPDATE;
            idx_d = '0;
        end
        if (state_q == UPDATE) begin
            cur_d[idx_q] = nxt;
            width_pend_d[idx_q] = W'(angle_to_cycles(int'(nxt), MIN_PULSE, STEP_CYC));
            state_d = idx_q == CW'(NUM_CH - 1) ? HOLD : UPDATE;
            idx_d = idx_q + CW'(1);
        end
        // widths go live only on the wrap so no pulse is ever cut or stretched
        if (state_q == HOLD && wrap) begin
            state_d = IDLE;
            width_act_d = width_pend_q;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            settled_d[i] = cur_d[i] == tgt_d[i];
            pwm_d[i] = ch_en[i] && cnt < width_act_q[i];
        end
        wr_ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q <= '0;
            wr_ready_q <= 1'b1;
            wr_err_q <= 1'b0;
            pwm_q <= '0;
            settled_q <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                tgt_q[i] <= HOME_A;
                cur_q[i] <= HOME_A;
                width_pend_q[i] <= HOME_W;
                width_act_q[i] <= HOME_W;
            end
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            wr_ready_q <= wr_ready_d;
            wr_err_q <= wr_err_d;
            pwm_q <= pwm_d;
            settled_q <= settled_d;
            tgt_q <= tgt_d;
            cur_q <= cur_d;
            width_pend_q <= width_pend_d;
            width_act_q <= width_act_d;
        end
    end

    assign wr.wr_ready = wr_ready_q;
    assign wr.wr_err = wr_err_q;
    assign pwm = pwm_q;
    assign settled = settled_q;
endmodule
